// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial sequence generator.
// Holds the FSM state encoding and operand normalization.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b11,
    DONE  = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 8;

  // Zero or oversize lengths mean "send the whole word".
  function automatic int norm_len(
    input int len,
    input int width
  );
    if (len == 0 || len > width)
      return width;
    return len;
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load left-shift register for the sequence generator.
// The MSB output is taken at bit len-1, the top of the active window.
module seq_shift_reg #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  input  logic [LEN_W-1:0] len,
  output logic             msb
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] aligned;

  assign aligned = q >> (len - 1'b1);
  assign msb     = aligned[0];

  // Load takes priority over shifting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q << 1;
    end
  end

endmodule

// File: rtl/sequence_generator.sv
// Serializes a pattern MSB-first with repeat count and idle gap.
// All outputs are registered; the first bit leaves one cycle after start.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  input  logic [CNT_W-1:0] gap,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] cap_pat;
  logic [LEN_W-1:0] cap_len;
  logic [CNT_W-1:0] cap_gap;
  logic [LEN_W-1:0] bitcnt;
  logic [CNT_W-1:0] repcnt;
  logic [CNT_W-1:0] gapcnt;

  logic [LEN_W-1:0] len_n;
  logic [CNT_W-1:0] reps_n;
  logic [WIDTH-1:0] pat_sh;
  logic [WIDTH-1:0] cap_sh;
  logic             pat_first;
  logic             cap_first;

  logic             accept;
  logic             rel_shift;
  logic             rel_gap;
  logic             sr_load;
  logic             sr_shift;
  logic [WIDTH-1:0] sr_d;
  logic             sr_msb;

  assign len_n  = LEN_W'(norm_len(int'(len), WIDTH));
  assign reps_n = (reps == '0) ? CNT_W'(1) : reps;

  assign pat_sh    = pattern >> (len_n - 1'b1);
  assign pat_first = pat_sh[0];
  assign cap_sh    = cap_pat >> (cap_len - 1'b1);
  assign cap_first = cap_sh[0];

  // Shift-register control: first load, gapless reload, post-gap reload.
  always_comb begin
    accept    = (state == IDLE) && start;
    rel_shift = (state == SHIFT) && (bitcnt == '0)
             && (repcnt != '0) && (cap_gap == '0);
    rel_gap   = (state == GAP) && (gapcnt <= CNT_W'(1));
    sr_load   = accept || rel_shift || rel_gap;
    sr_shift  = (state == SHIFT) && (bitcnt != '0);
    sr_d      = accept ? (pattern << 1) : (cap_pat << 1);
  end

  seq_shift_reg #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_sr (
    .CLK   (CLK),
    .RST   (RST),
    .load  (sr_load),
    .shift (sr_shift),
    .d     (sr_d),
    .len   (cap_len),
    .msb   (sr_msb)
  );

  // Main FSM with counters and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cap_pat <= '0;
      cap_len <= '0;
      cap_gap <= '0;
      bitcnt  <= '0;
      repcnt  <= '0;
      gapcnt  <= '0;
      x       <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cap_pat <= pattern;
            cap_len <= len_n;
            cap_gap <= gap;
            bitcnt  <= len_n - 1'b1;
            repcnt  <= reps_n - 1'b1;
            x       <= pat_first;
            valid   <= 1'b1;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bitcnt != '0) begin
            x      <= sr_msb;
            bitcnt <= bitcnt - 1'b1;
          end else if (repcnt != '0) begin
            repcnt <= repcnt - 1'b1;
            if (cap_gap != '0) begin
              gapcnt <= cap_gap;
              x      <= 1'b0;
              valid  <= 1'b0;
              state  <= GAP;
            end else begin
              x      <= cap_first;
              bitcnt <= cap_len - 1'b1;
            end
          end else begin
            x     <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        GAP: begin
          if (gapcnt <= CNT_W'(1)) begin
            gapcnt <= '0;
            x      <= cap_first;
            valid  <= 1'b1;
            bitcnt <= cap_len - 1'b1;
            state  <= SHIFT;
          end else begin
            gapcnt <= gapcnt - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
